// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 3-entry skid buffer, flagging burst ends.
// Latency: fifo_rd_en to m_valid is 2 clocks; one word per clock sustained with m_ready held high.
// Backpressure: reads stop once buffered plus in-flight words reach 3; fifo_rd_en never looks at m_ready.
// Optional FIFO_READER_STATS_EN adds word_cnt/burst_cnt transfer counters.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             flush,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]      word_cnt,
    output logic [31:0]      burst_cnt
`endif
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(BURST_LEN - 1);

    logic [WIDTH-1:0] r_buf [3];
    logic [1:0]       r_occ;
    logic             r_infl;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_buf_nxt [3];
    logic [1:0]       w_occ_pop;
    logic [1:0]       w_occ_nxt;
    logic [2:0]       w_pend;
    logic             w_xfer;

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf[0];
    assign m_last  = m_valid && (r_cnt == LP_LAST);
    assign w_xfer  = m_valid && m_ready;
    assign w_pend  = {1'b0, r_occ} + {2'b00, r_infl};

    // rst gates the strobe so an asynchronous reset silences the FIFO before the next edge.
    assign fifo_rd_en = !rst && !fifo_empty && !flush && (w_pend < 3'd3);

    // Pop shifts toward the head; the returning word lands behind whatever survives the pop.
    always_comb begin
        w_buf_nxt = r_buf;
        w_occ_pop = r_occ - {1'b0, w_xfer};
        if (w_xfer) begin
            w_buf_nxt[0] = r_buf[1];
            w_buf_nxt[1] = r_buf[2];
        end
        if (r_infl) begin
            case (w_occ_pop)
                2'd0:    w_buf_nxt[0] = fifo_dout;
                2'd1:    w_buf_nxt[1] = fifo_dout;
                default: w_buf_nxt[2] = fifo_dout;
            endcase
        end
    end

    assign w_occ_nxt = w_occ_pop + {1'b0, r_infl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '{default: '0};
            r_occ  <= 2'd0;
            r_infl <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_infl <= fifo_rd_en;
            r_buf  <= w_buf_nxt;
            if (flush) begin
                r_occ <= 2'd0;
                r_cnt <= '0;
            end else begin
                r_occ <= w_occ_nxt;
                if (w_xfer)
                    r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] r_word_cnt;
    logic [31:0] r_burst_cnt;

    // Statistics survive flush: a flushed transfer still reached the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt  <= 32'd0;
            r_burst_cnt <= 32'd0;
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            if (m_last)
                r_burst_cnt <= r_burst_cnt + 32'd1;
        end
    end

    assign word_cnt  = r_word_cnt;
    assign burst_cnt = r_burst_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO feeding the reader, scoreboard of expected stream words.
module tb_fifo_stream_reader;
    localparam int BL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       m_ready = 1'b0;
    logic       stall = 1'b1;
    logic       fifo_rd_en, fifo_empty, m_valid, m_last;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] m_data;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] word_cnt, burst_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [7:0] fmem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] exp_q [$];
    int         pend = 0;
    int         beat = 0;
    int         nxfer_total = 0;
    int         nlast_total = 0;
    logic       mon_xfer;
    logic       mon_last;
    logic [7:0] mon_e;

    always #5 clk = ~clk;

    assign fifo_empty = stall || (rd_ptr == wr_ptr);

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .flush(flush), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
`ifdef FIFO_READER_STATS_EN
        , .word_cnt(word_cnt), .burst_cnt(burst_cnt)
`endif
    );

    // FIFO model: registered read data one cycle after an accepted strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fmem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Scoreboard: every cycle, judge the transfer about to happen on the next rising edge.
    always @(negedge clk) begin
        nvec++;
        if (pend > 3) begin
            nerr++;
            $display("FAIL occupancy: occ+infl=%0d, limit 3", pend);
        end
        nvec++;
        if (fifo_rd_en && fifo_empty) begin
            nerr++;
            $display("FAIL rd_en_while_empty: fifo_rd_en=1 with fifo_empty=1");
        end
        if (rst) begin
            for (int k = 0; k < pend; k++)
                if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            pend = 0;
            beat = 0;
            nxfer_total = 0;
            nlast_total = 0;
        end else begin
            mon_xfer = m_valid && m_ready;
            if (mon_xfer) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_word: got %02h, expected nothing", m_data);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_last = (beat == BL - 1);
                    if (m_data !== mon_e) begin
                        nerr++;
                        $display("FAIL stream_data: got %02h, expected %02h", m_data, mon_e);
                    end
                    nvec++;
                    if (m_last !== mon_last) begin
                        nerr++;
                        $display("FAIL stream_last: got %0b, expected %0b (beat %0d)", m_last, mon_last, beat);
                    end
                    if (mon_last) nlast_total++;
                    beat = mon_last ? 0 : beat + 1;
                    nxfer_total++;
                end
            end
            if (flush) begin
                for (int k = 0; k < pend - int'(mon_xfer); k++)
                    if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                pend = 0;
                beat = 0;
            end else begin
                pend = pend + int'(fifo_rd_en) - int'(mon_xfer);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fmem[wr_ptr[9:0]] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        nvec++;
        if ({m_valid, m_last, fifo_rd_en, m_data} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_during: valid=%0b last=%0b rd_en=%0b data=%02h, all 0 expected",
                     m_valid, m_last, fifo_rd_en, m_data);
        end
        rst = 1'b0;
        repeat (3) tick();
        nvec++;
        if ({m_valid, m_last, fifo_rd_en, m_data} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_after: valid=%0b last=%0b rd_en=%0b data=%02h, all 0 expected",
                     m_valid, m_last, fifo_rd_en, m_data);
        end
    endtask

    task automatic test_streaming();
        int t, t_rd, t_v, n;
        logic exp_last;
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) push(8'(i));
        tick();
        stall = 1'b0;
        t = 0; t_rd = -1; t_v = -1; n = 0;
        while (n < 32 && t < 200) begin
            @(negedge clk);
            if (fifo_rd_en && t_rd < 0) t_rd = t;
            if (m_valid && t_v < 0) t_v = t;
            if (t_v >= 0) begin
                exp_last = (n == 15) || (n == 31);
                nvec++;
                if ({m_valid, m_last, m_data} !== {1'b1, exp_last, n[7:0]}) begin
                    nerr++;
                    $display("FAIL stream_consecutive: beat %0d valid=%0b last=%0b data=%02h, expected 1/%0b/%02h",
                             n, m_valid, m_last, m_data, exp_last, n[7:0]);
                end
                n++;
            end
            t++;
        end
        nvec++;
        if (t_v < 0 || t_rd < 0 || t_v - t_rd != 2) begin
            nerr++;
            $display("FAIL first_latency: rd_en at %0d, valid at %0d, 2 cycles expected", t_rd, t_v);
        end
        repeat (3) tick();
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL drained_valid: m_valid=%0b, 0 expected", m_valid);
        end
    endtask

    task automatic test_backpressure();
        int nrd, base, c;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
        nrd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd++;
            if (m_valid) begin
                nvec++;
                if (m_data !== 8'hA1) begin
                    nerr++;
                    $display("FAIL bp_stable: m_data=%02h, expected a1", m_data);
                end
            end
        end
        nvec++;
        if (nrd != 3) begin
            nerr++;
            $display("FAIL bp_reads: %0d reads while stalled, 3 expected", nrd);
        end
        nvec++;
        if ({m_valid, m_data} !== {1'b1, 8'hA1}) begin
            nerr++;
            $display("FAIL bp_head: valid=%0b data=%02h, expected 1/a1", m_valid, m_data);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        base = nxfer_total;
        c = 0;
        while (exp_q.size() > 0 && c < 100) begin tick(); c++; end
        repeat (2) tick();
        nvec++;
        if (nxfer_total - base != 5) begin
            nerr++;
            $display("FAIL bp_release: %0d words delivered, 5 expected", nxfer_total - base);
        end
    endtask

    task automatic test_random_ready();
        int base, c;
        base = nxfer_total;
        for (int i = 0; i < 200; i++) push(8'($urandom));
        c = 0;
        while (exp_q.size() > 0 && c < 5000) begin
            tick();
            m_ready = ($urandom_range(0, 1) == 1);
            stall   = ($urandom_range(0, 3) == 0);
            c++;
        end
        m_ready = 1'b1;
        stall   = 1'b0;
        repeat (3) tick();
        nvec++;
        if (nxfer_total - base != 200) begin
            nerr++;
            $display("FAIL random_count: %0d words delivered, 200 expected", nxfer_total - base);
        end
    endtask

    task automatic test_flush();
        int n, c, first_last;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 30; i++) push(8'h40 + 8'(i));
        n = 0; c = 0;
        while (n < 5 && c < 50) begin
            @(negedge clk);
            if (m_valid && m_ready) n++;
            c++;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        nvec++;
        if (pend != 3) begin
            nerr++;
            $display("FAIL flush_setup: occ+infl=%0d before flush, 3 expected", pend);
        end
        nvec++;
        if (fifo_rd_en !== 1'b0) begin
            nerr++;
            $display("FAIL flush_rd_en: fifo_rd_en=%0b in flush cycle, 0 expected", fifo_rd_en);
        end
        @(posedge clk); #1;
        flush   = 1'b0;
        m_ready = 1'b1;
        n = 0; c = 0; first_last = 0;
        while (n < 16 && c < 100) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n++;
                if (n == 1) begin
                    nvec++;
                    if (m_data !== 8'h48) begin
                        nerr++;
                        $display("FAIL flush_next_word: got %02h, expected 48", m_data);
                    end
                end
                if (m_last && first_last == 0) first_last = n;
            end
            c++;
        end
        nvec++;
        if (first_last != 16) begin
            nerr++;
            $display("FAIL flush_last_pos: first m_last on transfer %0d, 16 expected", first_last);
        end
        c = 0;
        while (exp_q.size() > 0 && c < 100) begin tick(); c++; end
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        int c;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(8'h90 + 8'(i));
        c = 0;
        while (!m_valid && c < 20) begin tick(); c++; end
        tick();
        #2;
`ifdef FIFO_READER_STATS_EN
        nvec++;
        if (word_cnt !== 32'(nxfer_total) || burst_cnt !== 32'(nlast_total)) begin
            nerr++;
            $display("FAIL stats_count: word_cnt=%0d burst_cnt=%0d, expected %0d/%0d",
                     word_cnt, burst_cnt, nxfer_total, nlast_total);
        end
`endif
        nvec++;
        if (m_valid !== 1'b1) begin
            nerr++;
            $display("FAIL arst_setup: m_valid=%0b before reset, 1 expected", m_valid);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({m_valid, fifo_rd_en} !== 2'b00) begin
            nerr++;
            $display("FAIL arst_immediate: valid=%0b rd_en=%0b before next edge, 0/0 expected",
                     m_valid, fifo_rd_en);
        end
`ifdef FIFO_READER_STATS_EN
        nvec++;
        if ({word_cnt, burst_cnt} !== 64'd0) begin
            nerr++;
            $display("FAIL arst_stats: word_cnt=%0d burst_cnt=%0d, 0/0 expected", word_cnt, burst_cnt);
        end
`endif
        tick();
        rst = 1'b0;
        c = 0;
        while (exp_q.size() > 0 && c < 100) begin tick(); c++; end
        repeat (3) tick();
        nvec++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL arst_resume: %0d words undelivered, valid=%0b; 0/0 expected",
                     exp_q.size(), m_valid);
        end
    endtask

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random_ready();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion for the team's synchronous FIFO (rd_en / dout / empty, dout registered one cycle after an accepted read).
- Drains the FIFO and presents the data as a valid/ready stream.
- Uses a 3-entry output buffer so throughput is one word per clock with no combinational path from m_ready to fifo_rd_en.
- Groups words into bursts of BURST_LEN and flags the last word of each burst.

Parameters:
WIDTH, 8, data width in bits
BURST_LEN, 16, words per burst; m_last marks word BURST_LEN-1 of each burst; legal range 1..65535
CNT_W, 16, width of the internal beat counter; must satisfy 2^CNT_W >= BURST_LEN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
fifo_rd_en  out  1  read strobe to FIFO; asserted only while fifo_empty=0
fifo_dout  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en=1
fifo_empty  in  1  FIFO empty flag, sampled combinationally
flush  in  1  synchronous clear of buffer, in-flight word and beat counter
m_data  out  WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready from consumer
m_last  out  1  last word of current burst, qualified by m_valid

Behaviour:
- Reset (async, rst=1): all of the following are 0: buffer occupancy, in-flight flag, beat counter, m_valid, m_last, m_data, fifo_rd_en. Reset mid-burst discards all buffered and in-flight data.
- Internal state:
  - occ: 0..3 buffered words, FIFO-ordered, head drives m_data.
  - infl: 1 if fifo_rd_en was 1 in the previous cycle.
- Read issue: fifo_rd_en = !fifo_empty && !flush && (occ + infl) < 3. It depends only on registered state, fifo_empty and flush; it never depends on m_ready.
- Capture: when infl=1, fifo_dout is written to the buffer tail on that edge. Latency from fifo_rd_en to m_valid is 2 clocks (FIFO read, then capture).
- Output:
  - m_valid = (occ != 0); m_data = head entry.
  - A transfer occurs when m_valid && m_ready; the head is popped on that edge.
  - Simultaneous capture and pop leaves occ unchanged; data order is preserved.
- Stability: while m_valid=1 and m_ready=0, m_data and m_last hold stable.
- Throughput: with the FIFO non-empty and m_ready held at 1, one transfer per clock in steady state.
- Beat counter:
  - Increments on each transfer; wraps to 0 on the transfer where count == BURST_LEN-1.
  - m_last = m_valid && (count == BURST_LEN-1).
  - BURST_LEN=1 means m_last=1 on every word.
- flush=1:
  - On the edge: occ:=0; the in-flight word (infl=1) is discarded, not captured; count:=0.
  - fifo_rd_en=0 in the flush cycle.
  - A transfer in the same cycle as flush is still counted as delivered to the consumer, but the counter ends at 0.
- FIFO empty: no reads issued; buffered words continue to drain; m_valid falls after the last buffered word transfers.
- Never overflow the buffer: occ + infl never exceeds 3. The bench asserts this.

Optional Feature:
- FIFO_READER_STATS_EN defined:
  - Adds output ports word_cnt (32-bit) and burst_cnt (32-bit).
  - word_cnt increments on every transfer; burst_cnt increments on every transfer with m_last=1.
  - Both wrap at 2^32, reset to 0 on rst, and are unaffected by flush.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: rst pulse, fifo_empty=1 -> m_valid=0, m_last=0, fifo_rd_en=0, m_data=0 during and after reset.
- Streaming: FIFO preloaded 0x00..0x1F, m_ready=1, BURST_LEN=16 ->
  - first m_valid 2 clocks after first fifo_rd_en;
  - 32 transfers on 32 consecutive cycles, in order;
  - m_last=1 on 0x0F and 0x1F only.
- Backpressure: FIFO holds 0xA1..0xA5, m_ready=0 for 10 cycles ->
  - fifo_rd_en stops after 3 reads;
  - m_data=0xA1 stable, m_valid=1;
  - releasing m_ready delivers 0xA1..0xA5 in order with no loss or duplication.
- Random ready: 200 words, m_ready toggled pseudo-randomly, fifo_empty bursty -> output sequence equals input; occ+infl<=3 every cycle; m_last every 16th transfer.
- Flush mid-burst: after 5 transfers of a burst, with occ=2 and infl=1, pulse flush ->
  - buffered and in-flight words are dropped;
  - the next word read from the FIFO is delivered first;
  - m_last occurs on the 16th transfer after the flush.
- Async reset mid-stream: assert rst between clock edges while m_valid=1 -> m_valid and fifo_rd_en drop immediately (before the next edge); with stats enabled, word_cnt=0 and burst_cnt=0.
